mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle control unit for the RV32I core; drives the select lines of the PC/ALU/write-back muxes (2:1, 4:1) and the PC/IR/memory/regfile enables.
//  Sequences each instruction through IF/ID/EX/MEM/WB with a ready handshake on the unified memory. Halts on ECALL with x17==10 (halt_req, decoded outside).
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  opcode       in   7      IR[6:0]; stable from ID until return to IF
//  alu_bcond    in   1      branch condition from ALU (valid in EX)
//  halt_req     in   1      ECALL with x17==10 (valid in ID)
//  mem_ready    in   1      memory completes current request this cycle
//  pc_write     out  1      PC register load enable
//  pc_source    out  2      00 PC+4 adder, 01 ALUOut reg, 10 ALU result
//  i_or_d       out  1      memory address: 0 PC, 1 ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  ir_write     out  1      IR load enable
//  alu_src_a    out  1      0 PC, 1 reg A
//  alu_src_b    out  2      00 reg B, 01 const 4, 10 imm
//  alu_op       out  2      00 add, 01 branch compare, 10 R funct, 11 I funct
//  reg_write    out  1      regfile write enable
//  wd_sel       out  2      write data: 00 ALUOut, 01 MDR, 10 PC+4
//  is_halted    out  1      sticky halt flag
//  retired      out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  States (3b): IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5. Moore outputs; every output 0 unless listed.
//  Reset low: state<=IF, retired<=0, all outputs forced 0 combinationally (mem_read/mem_write drop immediately). First fetch in first cycle after release.
//  IF: mem_read=1, i_or_d=0, ir_write=mem_ready. Stay until mem_ready, then ->ID.
//  ID: alu_src_a=0, alu_src_b=10, alu_op=00 (PC+imm into ALUOut).
//   ECALL(1110011): halt_req ? ->HALT : (pc_write=1, pc_source=00, ->IF).
//   JAL(1101111) ->WB; R/I/LOAD/STORE/BRANCH/JALR ->EX; unknown opcode treated as NOP like non-halt ECALL.
//  EX: R(0110011): src_a=1 src_b=00 op=10 ->WB. I(0010011): src_a=1 src_b=10 op=11 ->WB.
//   LOAD(0000011)/STORE(0100011): src_a=1 src_b=10 op=00 ->MEM. JALR(1100111): src_a=1 src_b=10 op=00 ->WB.
//   BRANCH(1100011): src_a=1 src_b=00 op=01, pc_write=1, pc_source=alu_bcond?01:00, ->IF.
//  MEM: i_or_d=1; LOAD mem_read=1, STORE mem_write=1; request held until mem_ready.
//   On mem_ready: LOAD ->WB; STORE pc_write=1 pc_source=00 ->IF.
//  WB: reg_write=1, pc_write=1 ->IF. R/I: wd_sel=00 pc_source=00. LOAD: wd_sel=01 pc_source=00.
//   JAL: wd_sel=10 pc_source=01. JALR: wd_sel=10 pc_source=10, ALU controls held at EX values.
//  HALT: is_halted=1, all other outputs 0, absorbing until reset; mem_ready ignored.
//  retired: +1 on every clock edge where state!=IF and next state is IF; wraps mod 2^CNT_W. Never increments on entry to HALT.
//  mem_ready may rise in the same cycle as the request (zero wait). mem_ready outside IF/MEM is ignored.
//  ir_write asserted only in IF, never twice per instruction.
// TESTING
//  1 Release reset, opcode=0110011, mem_ready=1 -> IF,ID,EX,WB, IF at cycle 4; reg_write=1 wd_sel=00 only in WB; retired=1.
//  2 LOAD, mem_ready high on 3rd cycle of IF and of MEM -> mem_read held throughout; ir_write single pulse; WB wd_sel=01; next IF at cycle 9.
//  3 BRANCH, bcond=1 -> EX pc_write=1 pc_source=01; bcond=0 -> pc_source=00; each 3 cycles; retired +1 each.
//  4 ECALL halt_req=1 -> HALT in cycle 2, is_halted=1, no pc_write; hold 100 cycles toggling mem_ready: state, retired unchanged.
//  5 JAL then JALR -> WB reg_write=1 wd_sel=10, pc_source=01 / pc_source=10 with src_a=1 src_b=10; JAL skips EX (3 cycles).
//  6 STORE, assert reset mid-MEM -> mem_write=0 same cycle, retired=0; after release IF with mem_read=1 next cycle.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: decoded-instruction inputs and memory handshake in,
// datapath mux selects and enables out.
interface mc_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             alu_bcond;
  logic             halt_req;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic [1:0]       wd_sel;
  logic             is_halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, alu_bcond, halt_req, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_write, wd_sel, is_halted, retired
  );

  modport slave (
    output opcode, alu_bcond, halt_req, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_write, wd_sel, is_halted, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: IF/ID/EX/MEM/WB sequencing over a unified
// memory with a ready handshake, sticky halt, and a retired-instruction counter.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mc_control_fsm_if.master  bus
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf:  if (bus.mem_ready) state_d = StId;
      StId: begin
        unique case (bus.opcode)
          OpEcall:                                       state_d = bus.halt_req ? StHalt : StIf;
          OpJal:                                         state_d = StWb;
          OpR, OpI, OpLoad, OpStore, OpBranch, OpJalr:  state_d = StEx;
          default:                                       state_d = StIf;
        endcase
      end
      StEx: begin
        unique case (bus.opcode)
          OpR, OpI, OpJalr: state_d = StWb;
          OpLoad, OpStore:  state_d = StMem;
          default:          state_d = StIf;
        endcase
      end
      StMem: if (bus.mem_ready) state_d = (bus.opcode == OpLoad) ? StWb : StIf;
      StWb:   state_d = StIf;
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // An instruction retires on any return to fetch; HALT is absorbing so never counts.
  assign retire = (state_q != StIf) && (state_d == StIf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIf;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.retired = retired_q;

  // Decoded from the current state; gated by reset so memory requests drop at once.
  always_comb begin
    bus.pc_write  = 1'b0;
    bus.pc_source = 2'b00;
    bus.i_or_d    = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.alu_op    = 2'b00;
    bus.reg_write = 1'b0;
    bus.wd_sel    = 2'b00;
    bus.is_halted = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIf: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
        end
        StId: begin
          bus.alu_src_b = 2'b10;
          if ((bus.opcode == OpEcall && !bus.halt_req) ||
              !(bus.opcode inside {OpEcall, OpJal, OpR, OpI, OpLoad, OpStore, OpBranch,
                                   OpJalr})) begin
            bus.pc_write = 1'b1;
          end
        end
        StEx: begin
          bus.alu_src_a = 1'b1;
          unique case (bus.opcode)
            OpR: bus.alu_op = 2'b10;
            OpI: begin
              bus.alu_src_b = 2'b10;
              bus.alu_op    = 2'b11;
            end
            OpLoad, OpStore, OpJalr: bus.alu_src_b = 2'b10;
            OpBranch: begin
              bus.alu_op    = 2'b01;
              bus.pc_write  = 1'b1;
              bus.pc_source = bus.alu_bcond ? 2'b01 : 2'b00;
            end
            default: bus.alu_src_a = 1'b1;
          endcase
        end
        StMem: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (bus.opcode == OpLoad);
          bus.mem_write = (bus.opcode == OpStore);
          bus.pc_write  = bus.mem_ready && (bus.opcode == OpStore);
        end
        StWb: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          unique case (bus.opcode)
            OpLoad: bus.wd_sel = 2'b01;
            OpJal: begin
              bus.wd_sel    = 2'b10;
              bus.pc_source = 2'b01;
            end
            OpJalr: begin
              bus.wd_sel    = 2'b10;
              bus.pc_source = 2'b10;
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'b10;
            end
            default: bus.wd_sel = 2'b00;
          endcase
        end
        StHalt:  bus.is_halted = 1'b1;
        default: bus.is_halted = 1'b0;
      endcase
    end
  end

endmodule
